mux_scan_ctrl: RTL and testbench

//  Scan sequencer for the 8-to-1 mux tree built from 2-to-1 mux cells. Steps the
//  mux select through every channel, waits a settle window per channel to cover the
//  mux propagation delay, samples the mux output and assembles all channels into one

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux_scan_ctrl_settle_timer.sv | 32 +++
 rtl/mux_scan_ctrl.sv | 99 +++++++++
 tb/tb_mux_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared FSM state encodings and default settle window for the mux scan sequencer.
// Also used by the mux-tree bench so both sides agree on the state numbering.
package mux_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SETTLE_CYC_DEF = 2;
  // Wide enough for the largest legal settle window (15 cycles).
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle-window counter: counts cycles while enabled, flags the last settle cycle.
// Latency: tc is combinational from the count; the count updates one edge after enable.
// Backpressure: none; clear has priority over enable.
module settle_timer
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = enable && (count == TC_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux-tree scan sequencer: steps sel over all channels and assembles sampled bits into data_out.
// Latency: done 2**N_SEL*(SETTLE_CYC+1) cycles after start; start while busy is ignored.
// Optional MUX_SCAN_CONT_EN adds the cont port for back-to-back scans without returning to IDLE.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_SEL      = 3,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mux_p,
`ifdef MUX_SCAN_CONT_EN
  input  logic                  cont,
`endif
  output logic [N_SEL-1:0]      sel,
  output logic                  busy,
  output logic                  done,
  output logic [2**N_SEL-1:0]   data_out
);

  localparam int               N_CH     = 2**N_SEL;
  localparam logic [N_SEL-1:0] SEL_LAST = N_SEL'(N_CH - 1);

  logic [1:0]      state;
  logic [N_CH-1:0] shadow;
  logic [N_CH-1:0] shadow_nxt;
  logic            settle_tc;
  logic            cont_en;

`ifdef MUX_SCAN_CONT_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif

  // Count is held at zero outside SETTLE so every channel starts a fresh window.
  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_SETTLE),
    .enable (state == ST_SETTLE),
    .tc     (settle_tc)
  );

  // Shadow with the current channel's sample merged in; the last channel goes
  // straight to data_out through this path.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[sel] = mux_p;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      shadow   <= '0;
      data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel <= '0;
          if (start) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_tc) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shadow <= shadow_nxt;
          if (sel == SEL_LAST) begin
            data_out <= shadow_nxt;
            state    <= ST_DONE;
          end else begin
            sel   <= sel + 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          sel   <= '0;
          state <= cont_en ? ST_SETTLE : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural mux tree plus a cycle-indexed reference model of the scan.
// Define MUX_SCAN_CONT_EN for both bench and RTL to exercise continuous mode.
module tb_mux_scan_ctrl;

  localparam int N_SEL  = 3;
  localparam int N_CH   = 8;
  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 1;
  localparam int SCAN   = N_CH * PER;
  localparam int TR_LEN = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] chan = 8'h00;
  logic       mux_p;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
`ifdef MUX_SCAN_CONT_EN
  logic       cont = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Per-cycle trace; index c means the cycle right after the c-th edge past the start edge.
  logic [7:0] tr_chan [TR_LEN];
  logic [2:0] tr_sel  [TR_LEN];
  logic       tr_busy [TR_LEN];
  logic       tr_done [TR_LEN];
  logic [7:0] tr_data [TR_LEN];
  logic [7:0] tr_prev;

  always #10 clk = ~clk;

  // Behavioural mux tree: output follows the addressed channel.
  assign mux_p = chan[sel];

  mux_scan_ctrl #(
    .N_SEL      (N_SEL),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mux_p    (mux_p),
`ifdef MUX_SCAN_CONT_EN
    .cont     (cont),
`endif
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  // mode 0: fixed word; mode 1: new random word every cycle; mode 2: channel 2 glitches around its sample.
  function automatic logic [7:0] gen_chan(input int mode, input logic [7:0] base, input int c);
    logic [7:0] v;
    v = base;
    if (mode == 1) v = 8'($urandom);
    if (mode == 2) begin
      if (c == 6) v[2] = 1'b1;
      if (c == 7) v[2] = 1'b0;
      if (c == 8) v[2] = 1'b1;
      if (c == 9) v[2] = 1'b0;
    end
    return v;
  endfunction

  // Channel i is captured at the closing edge of the last cycle of its window.
  function automatic logic [7:0] model_word();
    logic [7:0] w;
    logic [7:0] v;
    for (int i = 0; i < N_CH; i++) begin
      v    = tr_chan[i*PER + PER - 1];
      w[i] = v[i];
    end
    return w;
  endfunction

  task automatic run_scan(input int mode, input logic [7:0] base, input int restart_at, input int ncyc);
    @(negedge clk);
    tr_prev = data_out;
    start   = 1'b1;
    chan    = base;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chan       = gen_chan(mode, base, c);
      start      = (c == restart_at);
      tr_chan[c] = chan;
      tr_sel[c]  = sel;
      tr_busy[c] = busy;
      tr_done[c] = done;
      tr_data[c] = data_out;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sel !== 3'd0)      begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_scan();
    logic [7:0] base;
    logic [7:0] exp_w;
    for (int p = 0; p < 5; p++) begin
      base = (p == 0) ? 8'hA5 : 8'($urandom);
      run_scan(0, base, -1, SCAN + 2);
      exp_w = model_word();
      checks++; if (exp_w !== base) begin errors++; $display("FAIL scan_model_word got=%h exp=%h", exp_w, base); end
      for (int c = 0; c < SCAN + 2; c++) begin
        if (c < SCAN) begin
          checks++; if (tr_sel[c] !== 3'(c / PER)) begin errors++; $display("FAIL scan_sel c=%0d got=%0d exp=%0d", c, tr_sel[c], c / PER); end
          checks++; if (tr_busy[c] !== 1'b1) begin errors++; $display("FAIL scan_busy c=%0d got=%b exp=1", c, tr_busy[c]); end
          checks++; if (tr_done[c] !== 1'b0) begin errors++; $display("FAIL scan_early_done c=%0d got=%b exp=0", c, tr_done[c]); end
          checks++; if (tr_data[c] !== tr_prev) begin errors++; $display("FAIL scan_data_hold c=%0d got=%h exp=%h", c, tr_data[c], tr_prev); end
        end else if (c == SCAN) begin
          checks++; if (tr_done[c] !== 1'b1) begin errors++; $display("FAIL scan_done c=%0d got=%b exp=1", c, tr_done[c]); end
          checks++; if (tr_busy[c] !== 1'b1) begin errors++; $display("FAIL scan_done_busy got=%b exp=1", tr_busy[c]); end
          checks++; if (tr_data[c] !== exp_w) begin errors++; $display("FAIL scan_data got=%h exp=%h", tr_data[c], exp_w); end
        end else begin
          checks++; if (tr_busy[c] !== 1'b0) begin errors++; $display("FAIL scan_idle_busy got=%b exp=0", tr_busy[c]); end
          checks++; if (tr_done[c] !== 1'b0) begin errors++; $display("FAIL scan_idle_done got=%b exp=0", tr_done[c]); end
          checks++; if (tr_sel[c] !== 3'd0) begin errors++; $display("FAIL scan_idle_sel got=%0d exp=0", tr_sel[c]); end
          checks++; if (tr_data[c] !== exp_w) begin errors++; $display("FAIL scan_data_after got=%h exp=%h", tr_data[c], exp_w); end
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int n_done;
    logic [7:0] exp_w;
    run_scan(0, 8'h5A, 10, SCAN + 8);
    exp_w  = model_word();
    n_done = 0;
    for (int c = 0; c < SCAN + 8; c++) begin
      if (tr_done[c]) n_done++;
      if (c < SCAN) begin
        checks++; if (tr_sel[c] !== 3'(c / PER)) begin errors++; $display("FAIL restart_sel c=%0d got=%0d exp=%0d", c, tr_sel[c], c / PER); end
        checks++; if (tr_data[c] !== tr_prev) begin errors++; $display("FAIL restart_data_hold c=%0d got=%h exp=%h", c, tr_data[c], tr_prev); end
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done_count got=%0d exp=1", n_done); end
    checks++; if (tr_done[SCAN] !== 1'b1) begin errors++; $display("FAIL restart_done_pos got=%b exp=1", tr_done[SCAN]); end
    checks++; if (tr_data[SCAN] !== exp_w) begin errors++; $display("FAIL restart_data got=%h exp=%h", tr_data[SCAN], exp_w); end
    checks++; if (tr_busy[SCAN + 7] !== 1'b0) begin errors++; $display("FAIL restart_idle_busy got=%b exp=0", tr_busy[SCAN + 7]); end
  endtask

  task automatic test_reset_mid_scan();
    bit hit;
    int n_done;
    @(negedge clk);
    start = 1'b1;
    chan  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if (sel == 3'd4) hit = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_sel4 got=timeout exp=sel4"); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sel !== 3'd0)       begin errors++; $display("FAIL midrst_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", data_out); end
    rst_n  = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle got=%b exp=0", busy); end
    run_scan(0, 8'h3C, -1, SCAN + 2);
    checks++; if (tr_done[SCAN] !== 1'b1) begin errors++; $display("FAIL midrst_rescan_done got=%b exp=1", tr_done[SCAN]); end
    checks++; if (tr_data[SCAN] !== 8'h3C) begin errors++; $display("FAIL midrst_rescan_data got=%h exp=3c", tr_data[SCAN]); end
  endtask

  task automatic test_settle_glitch();
    logic [7:0] exp_w;
    run_scan(2, 8'h00, -1, SCAN + 2);
    checks++; if (tr_data[SCAN] !== 8'h04) begin errors++; $display("FAIL glitch_ch2 got=%h exp=04", tr_data[SCAN]); end
    run_scan(2, 8'hFB, -1, SCAN + 2);
    checks++; if (tr_data[SCAN] !== 8'hFF) begin errors++; $display("FAIL glitch_ch2_hi got=%h exp=ff", tr_data[SCAN]); end
    for (int p = 0; p < 6; p++) begin
      run_scan(1, 8'h00, -1, SCAN + 2);
      exp_w = model_word();
      checks++; if (tr_data[SCAN] !== exp_w) begin errors++; $display("FAIL random_chan p=%0d got=%h exp=%h", p, tr_data[SCAN], exp_w); end
      checks++; if (tr_done[SCAN] !== 1'b1) begin errors++; $display("FAIL random_done p=%0d got=%b exp=1", p, tr_done[SCAN]); end
    end
  endtask

`ifdef MUX_SCAN_CONT_EN
  task automatic test_back_to_back();
    localparam int P2 = SCAN + 1;
    logic [7:0] pat [3];
    int s;
    int k;
    pat[0] = 8'hFF;
    pat[1] = 8'h0F;
    pat[2] = 8'($urandom);
    @(negedge clk);
    cont  = 1'b1;
    start = 1'b1;
    chan  = pat[0];
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3*P2 + 3; c++) begin
      s = c / P2;
      k = c % P2;
      if (s < 3) chan = pat[s];
      if (c == 2*P2 + 5) cont = 1'b0;
      if (c < 3*P2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy c=%0d got=%b exp=1", c, busy); end
        checks++; if (done !== (k == SCAN)) begin errors++; $display("FAIL cont_done c=%0d got=%b exp=%b", c, done, k == SCAN); end
        if (k == SCAN) begin
          checks++; if (data_out !== pat[s]) begin errors++; $display("FAIL cont_data s=%0d got=%h exp=%h", s, data_out, pat[s]); end
        end
      end else begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy c=%0d got=%b exp=0", c, busy); end
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_scan();
    test_restart_ignored();
    test_reset_mid_scan();
    test_settle_glitch();
`ifdef MUX_SCAN_CONT_EN
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
